uart_rx_cfg: RTL and testbench
==============================

# uart_rx_cfg

Parametrised UART receiver, successor to the fixed 8N1 receiver. Supports configurable data width, stop-bit count and optional parity. Majority-voted mid-bit sampling, false-start rejection, and framing/parity/overrun flags. Delivers frames through a valid/ready holding register. Sits between the pad-side `rxd` line and any byte-stream consumer (FIFO, command parser).

## Interface
Parameters:
- `CLK_FREQ`, 48000000, system clock in Hz
- `BAUD`, 115200, line rate in bit/s; `BAUD_DIV = CLK_FREQ/BAUD` must be ≥ 8 (elaboration error otherwise)
- `DATA_BITS`, 8, payload bits per frame, legal 5..9
- `STOP_BITS`, 1, legal 1 or 2
- `PARITY_ODD`, 0, 0 = even, 1 = odd; only used when parity is compiled in

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `rxd`  in  1  serial line, idle high, asynchronous to `clk`
- `rx_data`  out  DATA_BITS  received payload, LSB = first bit on the line
- `rx_valid`  out  1  `rx_data`/flags hold a frame
- `rx_ready`  in  1  consumer accepts when `rx_valid && rx_ready`
- `frame_err`  out  1  stop bit sampled low; qualified by `rx_valid`
- `parity_err`  out  1  parity mismatch; qualified by `rx_valid`; constant 0 without parity
- `overrun`  out  1  one-cycle pulse when a completed frame is dropped
- `rx_busy`  out  1  FSM not in IDLE

## Operation
- `rxd` passes through a 2-flop synchronizer (`rxd_s`). A start is the falling edge of `rxd_s`, seen in IDLE only.
- Bit counter `baud_cnt` runs 0..BAUD_DIV-1 and is cleared on start detection. Sample point is `MID = BAUD_DIV/2`. Bit value is the majority of `rxd_s` at MID-1, MID and MID+1.
- FSM states and transitions:
  - IDLE → START on falling edge.
  - START, at MID+1: majority 1 → IDLE (false start, no flags); majority 0 → DATA.
  - DATA: shifts DATA_BITS samples LSB-first. Then → PARITY if compiled in, else → STOP.
  - PARITY: one bit compared against XOR of the data bits XOR `PARITY_ODD`.
  - STOP: `STOP_BITS` samples. Any stop sample 0 sets frame_err. After the last stop sample → IDLE at MID+1 (half bit early), so back-to-back frames are not lost.
- Completion loads `rx_data`, `frame_err`, `parity_err` into the holding register and sets `rx_valid`.
- Frames with errors are still delivered, with the flags set.
- `rx_valid` stays high until a handshake cycle. Flags and data are stable while `rx_valid` is high.
- Overrun:
  - Completion while `rx_valid && !rx_ready`: new frame discarded, held frame kept, `overrun` = 1 for one cycle.
  - Completion in the same cycle as a handshake: new frame loaded, `rx_valid` stays 1, no overrun.
- Break (line held low): frame completes with `frame_err` = 1. No new start is accepted until `rxd_s` returns high and falls again.
- Reset, including mid-frame: FSM IDLE, counters 0, synchronizer flops 1, `rx_data` 0. `rx_valid`, `frame_err`, `parity_err`, `overrun` and `rx_busy` all 0.

## Timing
- Synchronizer latency is 2 cycles. Start detection registers in the cycle after `rxd_s` falls.
- `rx_valid` rises at most 3 cycles after the mid-point of the last stop bit.
- `rx_busy` rises the cycle after start detection and falls the cycle the FSM returns to IDLE.
- Handshake is AXI-style: `rx_ready` may be held high permanently. `rx_valid` never depends combinationally on `rx_ready`.
- Tolerates ±2% baud mismatch over a 12-bit frame.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state, `PARITY_ODD` check and `parity_err` are compiled in. Frame = start + DATA_BITS + parity + STOP_BITS.
- Undefined: no parity bit is expected on the line, `parity_err` is tied 0, and PARITY is absent from the state encoding.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum `uart_rx_state_t` (IDLE, START, DATA, PARITY, STOP)
  - function `baud_div(clk_freq, baud)`
  - constants for legal DATA_BITS/STOP_BITS ranges
  - `UART_MAJ_TAPS = 3`
- One sub-module, `uart_rx_sync`: 2-flop synchronizer with reset value 1, plus falling-edge detect output. Reused by the future transmitter's CTS input.

## Test plan
Bench settings: CLK_FREQ = 1600000, BAUD = 100000 (BAUD_DIV = 16), `rx_ready` = 1 unless stated.
- 8N1 byte 0xA5 → `rx_data` = 0xA5, `rx_valid` for 1 cycle, both flags 0.
- Parity build, even, DATA_BITS = 7, send 0x53 with parity bit 1 (wrong) → `rx_data` = 0x53, `parity_err` = 1. Correct bit 0 → `parity_err` = 0.
- Low glitch of 4 cycles on idle line → `rx_busy` pulses, returns to IDLE, no `rx_valid`.
- Stop bit forced 0 on byte 0x3C → `rx_data` = 0x3C, `frame_err` = 1. Then 20-bit break → one frame 0x00 with `frame_err` = 1 and no further frames until line high.
- `rx_ready` = 0, send 0x11 then 0x22 back-to-back → `overrun` pulse 1 cycle, `rx_data` stays 0x11. `rx_ready` pulse then yields the next frame 0x33 normally.
- Assert `rst_n` low during data bit 4 of 0xFF → all outputs 0 next edge. After release, frame 0x81 received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud divider helper and
// legal parameter ranges. Build option UART_RX_PARITY_EN adds the PARITY
// state to the state encoding.
package uart_pkg;

  localparam int UART_MAJ_TAPS      = 3;
  localparam int UART_MIN_DATA_BITS = 5;
  localparam int UART_MAX_DATA_BITS = 9;
  localparam int UART_MIN_STOP_BITS = 1;
  localparam int UART_MAX_STOP_BITS = 2;
  localparam int UART_MIN_BAUD_DIV  = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;
`endif

  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial input, idling high,
// with a falling-edge strobe on the synchronized signal. Also intended for
// the transmitter's CTS input.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Metastability chain plus one history flop for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign fall     = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver with majority-voted mid-bit sampling,
// false-start rejection, framing/parity/overrun flags and a valid/ready
// holding register. Define UART_RX_PARITY_EN to expect a parity bit.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 48000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam int CNT_W    = $clog2(BAUD_DIV);
  localparam int MID      = BAUD_DIV / 2;

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] TAP_EARLY = CNT_W'(MID - 1);
  localparam logic [CNT_W-1:0] TAP_MID   = CNT_W'(MID);
  localparam logic [CNT_W-1:0] TAP_LATE  = CNT_W'(MID + 1);
  localparam logic [3:0]       LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]       LAST_STOP = 4'(STOP_BITS - 1);

  if (BAUD_DIV < UART_MIN_BAUD_DIV) begin : g_bad_baud_div
    $error("uart_rx_cfg: CLK_FREQ/BAUD must be at least 8");
  end
  if (DATA_BITS < UART_MIN_DATA_BITS || DATA_BITS > UART_MAX_DATA_BITS) begin : g_bad_data_bits
    $error("uart_rx_cfg: DATA_BITS must be 5..9");
  end
  if (STOP_BITS < UART_MIN_STOP_BITS || STOP_BITS > UART_MAX_STOP_BITS) begin : g_bad_stop_bits
    $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
  end
  if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_parity_odd
    $error("uart_rx_cfg: PARITY_ODD must be 0 or 1");
  end

  logic                     rxd_s;
  logic                     rxd_fall;
  uart_rx_state_t           state;
  uart_rx_state_t           state_d;
  logic [CNT_W-1:0]         baud_cnt;
  logic [3:0]               bit_cnt;
  logic [UART_MAJ_TAPS-2:0] taps;
  logic                     maj;
  logic                     tick;
  logic                     load_frame;
  logic                     accept;
  logic [DATA_BITS-1:0]     shift_q;
  logic                     stop_err_q;
  logic                     frame_err_d;

  uart_rx_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (rxd),
    .sync_out (rxd_s),
    .fall     (rxd_fall)
  );

  // The third vote is the live sample at MID+1, when every bit decision is made.
  assign maj         = (taps[1] & taps[0]) | (taps[1] & rxd_s) | (taps[0] & rxd_s);
  assign tick        = (state != IDLE) && (baud_cnt == TAP_LATE);
  assign frame_err_d = stop_err_q | ~maj;
  assign accept      = load_frame && (!rx_valid || rx_ready);
  assign rx_busy     = (state != IDLE);

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state logic; the frame completes half a bit early so the next start edge is caught.
  always_comb begin
    state_d    = state;
    load_frame = 1'b0;
    case (state)
      IDLE:  if (rxd_fall) state_d = START;
      START: if (tick) state_d = maj ? IDLE : DATA;
      DATA: begin
        if (tick && bit_cnt == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick) state_d = STOP;
`endif
      STOP: begin
        if (tick && bit_cnt == LAST_STOP) begin
          state_d    = IDLE;
          load_frame = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bit timing, vote taps, payload shifter and stop-bit error accumulation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      taps       <= '1;
      shift_q    <= '0;
      stop_err_q <= 1'b0;
    end else if (state == IDLE) begin
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      stop_err_q <= 1'b0;
    end else begin
      baud_cnt <= (baud_cnt == DIV_LAST) ? '0 : baud_cnt + 1'b1;
      if (baud_cnt == TAP_EARLY || baud_cnt == TAP_MID) begin
        taps <= {taps[0], rxd_s};
      end
      if (tick) begin
        bit_cnt <= (state_d != state) ? '0 : bit_cnt + 1'b1;
        if (state == DATA) begin
          shift_q <= {maj, shift_q[DATA_BITS-1:1]};
        end
        if (state == STOP && !maj) begin
          stop_err_q <= 1'b1;
        end
      end
    end
  end

  // Holding register: a completed frame is dropped only when the held one is not being taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (accept) begin
        rx_data   <= shift_q;
        frame_err <= frame_err_d;
        rx_valid  <= 1'b1;
      end else if (load_frame) begin
        overrun <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  // Parity check against the fully shifted payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_err_q <= 1'b0;
    end else if (tick && state == PARITY) begin
      par_err_q <= maj ^ (^shift_q) ^ 1'(PARITY_ODD);
    end
  end

  // Parity flag travels with the frame into the holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept) begin
      parity_err <= par_err_q;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg at BAUD_DIV = 16. With UART_RX_PARITY_EN
// defined the payload is 7 bits with even parity, otherwise 8N1.
module tb_uart_rx_cfg;

`ifdef UART_RX_PARITY_EN
  localparam int DW     = 7;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int DW     = 8;
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int DIV  = 16;
  localparam int PODD = 0;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ferr;
    logic          perr;
  } frame_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rxd = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;
  logic          rx_busy;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  int     ovr_cycles = 0;
  int     valid_cycles = 0;
  bit     busy_seen;

  always #5 clk = ~clk;

  uart_rx_cfg #(
    .CLK_FREQ   (1600000),
    .BAUD       (100000),
    .DATA_BITS  (DW),
    .STOP_BITS  (1),
    .PARITY_ODD (PODD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rxd        (rxd),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic driveBit(input logic b);
    rxd = b;
    repeat (DIV) @(posedge clk);
    #1;
  endtask

  task automatic idleBits(input int n);
    rxd = 1'b1;
    repeat (n * DIV) @(posedge clk);
    #1;
  endtask

  task automatic expectFrame(input logic [DW-1:0] d, input logic ferr, input logic perr);
    frame_t f;
    f.data = d;
    f.ferr = ferr;
    f.perr = perr;
    exp_q.push_back(f);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input logic par_flip,
                               input logic stop_val, input bit expect_it);
    if (expect_it) expectFrame(d, ~stop_val, par_flip & PAR_EN);
    driveBit(1'b0);
    for (int i = 0; i < DW; i++) driveBit(d[i]);
    if (PAR_EN) driveBit((^d) ^ 1'(PODD) ^ par_flip);
    driveBit(stop_val);
    rxd = 1'b1;
  endtask

  // Monitor: every accepted frame is compared against the oldest expectation.
  always @(negedge clk) begin
    frame_t f;
    if (rx_valid) valid_cycles++;
    if (overrun) ovr_cycles++;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_frame_queue", 32'(exp_q.size()), 32'd1);
      end else begin
        f = exp_q.pop_front();
        checkOutput("frame_data", 32'(rx_data), 32'(f.data));
        checkOutput("frame_err", 32'(frame_err), 32'(f.ferr));
        checkOutput("parity_err", 32'(parity_err), 32'(f.perr));
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n    = 1'b0;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("reset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("reset_overrun", 32'(overrun), 32'd0);
    checkOutput("reset_rx_busy", 32'(rx_busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleBits(2);

    // Clean frame, delivered for exactly one cycle with ready held high.
    valid_cycles = 0;
    applyStimulus(DW'(8'hA5), 1'b0, 1'b1, 1'b1);
    idleBits(2);
    checkOutput("a5_valid_cycles", 32'(valid_cycles), 32'd1);

`ifdef UART_RX_PARITY_EN
    // 0x53 has four ones: even parity bit 0, so 1 must flag an error.
    applyStimulus(DW'(7'h53), 1'b1, 1'b1, 1'b1);
    idleBits(2);
    applyStimulus(DW'(7'h53), 1'b0, 1'b1, 1'b1);
    idleBits(2);
`endif

    // Short low glitch: busy pulses, no frame.
    valid_cycles = 0;
    rxd = 1'b0;
    repeat (4) @(posedge clk);
    #1 rxd = 1'b1;
    busy_seen = 1'b0;
    for (int i = 0; i < 10 && !busy_seen; i++) begin
      @(negedge clk);
      if (rx_busy) busy_seen = 1'b1;
    end
    checkOutput("glitch_busy_rise", 32'(busy_seen), 32'd1);
    repeat (2 * DIV) @(negedge clk);
    checkOutput("glitch_busy_fall", 32'(rx_busy), 32'd0);
    checkOutput("glitch_no_valid", 32'(valid_cycles), 32'd0);
    @(posedge clk);
    #1;

    // Stop bit low, then a 20-bit break: exactly one all-zero frame with frame_err.
    applyStimulus(DW'(8'h3C), 1'b0, 1'b0, 1'b1);
    idleBits(2);
    expectFrame('0, 1'b1, 1'b0);
    rxd = 1'b0;
    repeat (20 * DIV) @(posedge clk);
    #1;
    checkOutput("break_idle_while_low", 32'(rx_busy), 32'd0);
    idleBits(3);

    // Overrun: second frame dropped while the first is held.
    rx_ready   = 1'b0;
    ovr_cycles = 0;
    applyStimulus(DW'(8'h11), 1'b0, 1'b1, 1'b1);
    applyStimulus(DW'(8'h22), 1'b0, 1'b1, 1'b0);
    idleBits(2);
    checkOutput("ovr_pulse_cycles", 32'(ovr_cycles), 32'd1);
    checkOutput("ovr_held_valid", 32'(rx_valid), 32'd1);
    checkOutput("ovr_held_data", 32'(rx_data), 32'(DW'(8'h11)));
    rx_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ovr_drained", 32'(rx_valid), 32'd0);
    applyStimulus(DW'(8'h33), 1'b0, 1'b1, 1'b1);
    idleBits(2);

    // Reset in the middle of data bit 4 of 0xFF.
    rxd = 1'b0;
    repeat (DIV) @(posedge clk);
    #1 rxd = 1'b1;
    repeat (4 * DIV + DIV / 2) @(posedge clk);
    #1;
    checkOutput("pre_reset_busy", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset_rx_busy", 32'(rx_busy), 32'd0);
    checkOutput("midreset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("midreset_rx_data", 32'(rx_data), 32'd0);
    checkOutput("midreset_frame_err", 32'(frame_err), 32'd0);
    checkOutput("midreset_parity_err", 32'(parity_err), 32'd0);
    checkOutput("midreset_overrun", 32'(overrun), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idleBits(2);
    applyStimulus(DW'(8'h81), 1'b0, 1'b1, 1'b1);
    idleBits(2);

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
